// File: rtl/uc_arbiter_if.sv
// uc_arbiter_if: engine request bus plus ucq push bus for the unit-clause arbiter.
//   clear      backtrack flush (to arbiter)
//   eng_valid  per-engine literal valid (to arbiter)
//   eng_lit    per-engine literal, MSB = negated (to arbiter)
//   eng_ready  one-hot or zero accept (from arbiter)
//   ucq_full   ucq full flag (to arbiter)
//   push       push strobe to the ucq (from arbiter)
//   uca2ucq    literal to the ucq (from arbiter)
//   conflict   sticky conflict flag (from arbiter)
//   dup_cnt    saturating dropped-duplicate count (from arbiter)
interface uc_arbiter_if #(
  parameter int N_ENG = 4,
  parameter int LIT_W = 11
);
  logic                        clear;
  logic [N_ENG-1:0]            eng_valid;
  logic [N_ENG-1:0][LIT_W-1:0] eng_lit;
  logic [N_ENG-1:0]            eng_ready;
  logic                        ucq_full;
  logic                        push;
  logic [LIT_W-1:0]            uca2ucq;
  logic                        conflict;
  logic [15:0]                 dup_cnt;
  modport master (
    output clear, eng_valid, eng_lit, ucq_full,
    input  eng_ready, push, uca2ucq, conflict, dup_cnt
  );
  modport slave (
    input  clear, eng_valid, eng_lit, ucq_full,
    output eng_ready, push, uca2ucq, conflict, dup_cnt
  );
endinterface

// File: rtl/uc_arbiter.sv
// uc_arbiter: round-robin unit-clause collector with duplicate drop and conflict detection.
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  uc_arbiter_if slave: engine requests in, ucq push out, status flags
module uc_arbiter #(
  parameter int N_ENG     = 4,
  parameter int UC_LENGTH = 1024,
  parameter int HIST_SIZE = 8
) (
  input logic        clk,
  input logic        rst,
  uc_arbiter_if.slave bus
);
  localparam int LIT_W = $clog2(UC_LENGTH) + 1;
  localparam int RW    = $clog2(N_ENG);
  localparam int HW    = $clog2(HIST_SIZE);
  logic                 out_valid_q, out_valid_d;
  logic [LIT_W-1:0]     out_lit_q, out_lit_d;
  logic                 conflict_q, conflict_d;
  logic [15:0]          dup_cnt_q, dup_cnt_d;
  logic [RW-1:0]        rr_q, rr_d;
  logic [HW-1:0]        wptr_q, wptr_d;
  logic [HIST_SIZE-1:0] hist_v_q, hist_v_d;
  logic [LIT_W-1:0]     hist_q [HIST_SIZE];
  logic                 push, slot_free, can_grant, req, gnt, dup, conf, load;
  logic [RW-1:0]        g;
  logic [LIT_W-1:0]     lit, nlit;
  assign push      = out_valid_q & ~bus.ucq_full;
  assign slot_free = ~out_valid_q | push;
  // rst gating makes eng_ready drop the instant reset asserts
  assign can_grant = rst & slot_free & ~bus.clear & ~conflict_q;
  // first valid engine at or after rr_q; scanning downward lets the nearest one win
  always_comb begin
    int t;
    req = 1'b0;
    g   = '0;
    for (int k = N_ENG - 1; k >= 0; k--) begin
      t = int'(rr_q) + k;
      t = (t >= N_ENG) ? t - N_ENG : t;
      if (bus.eng_valid[RW'(t)]) begin
        req = 1'b1;
        g   = RW'(t);
      end
    end
  end
  assign gnt  = req & can_grant;
  assign lit  = bus.eng_lit[g];
  assign nlit = {~lit[LIT_W-1], lit[LIT_W-2:0]};
  // the pending output literal counts as history too
  always_comb begin
    dup  = out_valid_q & (out_lit_q == lit);
    conf = out_valid_q & (out_lit_q == nlit);
    for (int i = 0; i < HIST_SIZE; i++) begin
      dup  = dup  | (hist_v_q[i] & (hist_q[i] == lit));
      conf = conf | (hist_v_q[i] & (hist_q[i] == nlit));
    end
  end
  assign load = gnt & ~dup & ~conf;
  always_comb begin
    out_valid_d = bus.clear ? 1'b0 : (load | (out_valid_q & ~push));
    out_lit_d   = load ? lit : out_lit_q;
    conflict_d  = ~bus.clear & (conflict_q | (gnt & ~dup & conf));
    dup_cnt_d   = (gnt & dup & ~&dup_cnt_q) ? dup_cnt_q + 16'd1 : dup_cnt_q;
    rr_d        = bus.clear ? '0 : gnt ? ((g == RW'(N_ENG - 1)) ? '0 : g + 1'b1) : rr_q;
    wptr_d      = bus.clear ? '0 : load ? ((wptr_q == HW'(HIST_SIZE - 1)) ? '0 : wptr_q + 1'b1) : wptr_q;
    hist_v_d    = bus.clear ? '0 : load ? (hist_v_q | ({{(HIST_SIZE-1){1'b0}}, 1'b1} << wptr_q)) : hist_v_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_lit_q   <= '0;
      conflict_q  <= 1'b0;
      dup_cnt_q   <= '0;
      rr_q        <= '0;
      wptr_q      <= '0;
      hist_v_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_lit_q   <= out_lit_d;
      conflict_q  <= conflict_d;
      dup_cnt_q   <= dup_cnt_d;
      rr_q        <= rr_d;
      wptr_q      <= wptr_d;
      hist_v_q    <= hist_v_d;
    end
  end
  // history data needs no reset; hist_v_q qualifies every entry
  always_ff @(posedge clk) begin
    if (load) hist_q[wptr_q] <= lit;
  end
  assign bus.eng_ready = gnt ? ({{(N_ENG-1){1'b0}}, 1'b1} << g) : '0;
  assign bus.push      = push;
  assign bus.uca2ucq   = out_lit_q;
  assign bus.conflict  = conflict_q;
  assign bus.dup_cnt   = dup_cnt_q;
endmodule

// File: tb/tb_uc_arbiter.sv
// tb_uc_arbiter: table-driven cycle vectors plus hand sequences for history wrap and async reset.
module tb_uc_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  uc_arbiter_if #(.N_ENG(4), .LIT_W(11)) bus ();
  uc_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [3:0]       v;
    logic [3:0][10:0] l;
    logic             full;
    logic             clr;
    logic [3:0]       rdy;
    logic             push;
    logic [10:0]      lit;
    logic             conf;
    logic [15:0]      dup;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t mk(logic [3:0] v, logic [10:0] l0, logic [10:0] l1, logic [10:0] l2,
                              logic [10:0] l3, logic full, logic clr, logic [3:0] rdy,
                              logic push, logic [10:0] lit, logic conf, logic [15:0] dup);
    vec_t r;
    r.v = v; r.l = {l3, l2, l1, l0}; r.full = full; r.clr = clr;
    r.rdy = rdy; r.push = push; r.lit = lit; r.conf = conf; r.dup = dup;
    return r;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(logic [3:0] v, logic [3:0][10:0] l, logic full, logic clr);
    bus.eng_valid = v;
    bus.eng_lit   = l;
    bus.ucq_full  = full;
    bus.clear     = clr;
  endtask
  initial begin
    drive('0, '0, 1'b0, 1'b0);
    // single forward
    tbl.push_back(mk(4'h0, 11'h000, 11'h000, 11'h000, 11'h000, 0, 0, 4'h0, 0, 11'h000, 0, 0));
    tbl.push_back(mk(4'h1, 11'h005, 11'h000, 11'h000, 11'h000, 0, 0, 4'h1, 0, 11'h000, 0, 0));
    tbl.push_back(mk(4'h0, 11'h000, 11'h000, 11'h000, 11'h000, 0, 0, 4'h0, 1, 11'h005, 0, 0));
    tbl.push_back(mk(4'h0, 11'h000, 11'h000, 11'h000, 11'h000, 0, 1, 4'h0, 0, 11'h005, 0, 0));
    // round robin from engine 0
    tbl.push_back(mk(4'hf, 11'h001, 11'h002, 11'h003, 11'h004, 0, 0, 4'h1, 0, 11'h005, 0, 0));
    tbl.push_back(mk(4'hf, 11'h001, 11'h002, 11'h003, 11'h004, 0, 0, 4'h2, 1, 11'h001, 0, 0));
    tbl.push_back(mk(4'hf, 11'h001, 11'h002, 11'h003, 11'h004, 0, 0, 4'h4, 1, 11'h002, 0, 0));
    tbl.push_back(mk(4'hf, 11'h001, 11'h002, 11'h003, 11'h004, 0, 0, 4'h8, 1, 11'h003, 0, 0));
    tbl.push_back(mk(4'h0, 11'h000, 11'h000, 11'h000, 11'h000, 0, 0, 4'h0, 1, 11'h004, 0, 0));
    // duplicate drop
    tbl.push_back(mk(4'h1, 11'h010, 11'h000, 11'h000, 11'h000, 0, 0, 4'h1, 0, 11'h004, 0, 0));
    tbl.push_back(mk(4'h4, 11'h000, 11'h000, 11'h010, 11'h000, 0, 0, 4'h4, 1, 11'h010, 0, 0));
    tbl.push_back(mk(4'h0, 11'h000, 11'h000, 11'h000, 11'h000, 0, 0, 4'h0, 0, 11'h010, 0, 1));
    // conflict, hold-off, clear
    tbl.push_back(mk(4'h1, 11'h020, 11'h000, 11'h000, 11'h000, 0, 0, 4'h1, 0, 11'h010, 0, 1));
    tbl.push_back(mk(4'h2, 11'h000, 11'h420, 11'h000, 11'h000, 0, 0, 4'h2, 1, 11'h020, 0, 1));
    tbl.push_back(mk(4'hf, 11'h031, 11'h032, 11'h033, 11'h034, 0, 0, 4'h0, 0, 11'h020, 1, 1));
    tbl.push_back(mk(4'hf, 11'h031, 11'h032, 11'h033, 11'h034, 0, 0, 4'h0, 0, 11'h020, 1, 1));
    tbl.push_back(mk(4'hf, 11'h031, 11'h032, 11'h033, 11'h034, 0, 1, 4'h0, 0, 11'h020, 1, 1));
    tbl.push_back(mk(4'hf, 11'h031, 11'h032, 11'h033, 11'h034, 0, 0, 4'h1, 0, 11'h020, 0, 1));
    tbl.push_back(mk(4'h0, 11'h000, 11'h000, 11'h000, 11'h000, 0, 0, 4'h0, 1, 11'h031, 0, 1));
    // backpressure for 5 cycles
    tbl.push_back(mk(4'h1, 11'h030, 11'h000, 11'h000, 11'h000, 0, 0, 4'h1, 0, 11'h031, 0, 1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(4'h2, 11'h000, 11'h035, 11'h000, 11'h000, 1, 0, 4'h0, 0, 11'h030, 0, 1));
    tbl.push_back(mk(4'h2, 11'h000, 11'h035, 11'h000, 11'h000, 0, 0, 4'h2, 1, 11'h030, 0, 1));
    tbl.push_back(mk(4'h0, 11'h000, 11'h000, 11'h000, 11'h000, 0, 0, 4'h0, 1, 11'h035, 0, 1));
    tbl.push_back(mk(4'h0, 11'h000, 11'h000, 11'h000, 11'h000, 0, 0, 4'h0, 0, 11'h035, 0, 1));
    // identical literal from two engines in one cycle
    tbl.push_back(mk(4'h9, 11'h040, 11'h000, 11'h000, 11'h040, 0, 0, 4'h8, 0, 11'h035, 0, 1));
    tbl.push_back(mk(4'h1, 11'h040, 11'h000, 11'h000, 11'h000, 0, 0, 4'h1, 1, 11'h040, 0, 1));
    tbl.push_back(mk(4'h0, 11'h000, 11'h000, 11'h000, 11'h000, 0, 0, 4'h0, 0, 11'h040, 0, 2));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].v, tbl[i].l, tbl[i].full, tbl[i].clr);
      #2;
      chk($sformatf("v%0d.eng_ready", i), 32'(bus.eng_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d.push", i), 32'(bus.push), 32'(tbl[i].push));
      chk($sformatf("v%0d.uca2ucq", i), 32'(bus.uca2ucq), 32'(tbl[i].lit));
      chk($sformatf("v%0d.conflict", i), 32'(bus.conflict), 32'(tbl[i].conf));
      chk($sformatf("v%0d.dup_cnt", i), 32'(bus.dup_cnt), 32'(tbl[i].dup));
    end
    // history wrap: 9 distinct literals through engine 0 after a clear
    @(negedge clk);
    drive(4'h0, '0, 1'b0, 1'b1);
    #2 chk("wrap.clear_push", 32'(bus.push), 32'd0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(4'h1, {33'h0, 11'(11'h100 + i)}, 1'b0, 1'b0);
      #2;
      chk($sformatf("wrap%0d.eng_ready", i), 32'(bus.eng_ready), 32'h1);
      if (i > 0) begin
        chk($sformatf("wrap%0d.push", i), 32'(bus.push), 32'd1);
        chk($sformatf("wrap%0d.uca2ucq", i), 32'(bus.uca2ucq), 32'h100 + 32'(i - 1));
      end
    end
    @(negedge clk);
    drive(4'h1, {33'h0, 11'h100}, 1'b0, 1'b0);
    #2;
    chk("wrap.resend_first.ready", 32'(bus.eng_ready), 32'h1);
    chk("wrap.ninth_push", 32'(bus.push), 32'd1);
    chk("wrap.ninth_lit", 32'(bus.uca2ucq), 32'h108);
    @(negedge clk);
    drive(4'h1, {33'h0, 11'h108}, 1'b0, 1'b0);
    #2;
    chk("wrap.first_forwarded_push", 32'(bus.push), 32'd1);
    chk("wrap.first_forwarded_lit", 32'(bus.uca2ucq), 32'h100);
    chk("wrap.resend_ninth.ready", 32'(bus.eng_ready), 32'h1);
    chk("wrap.dup_before", 32'(bus.dup_cnt), 32'd2);
    @(negedge clk);
    drive(4'h0, '0, 1'b0, 1'b0);
    #2;
    chk("wrap.ninth_dropped_push", 32'(bus.push), 32'd0);
    chk("wrap.ninth_dropped_lit", 32'(bus.uca2ucq), 32'h100);
    chk("wrap.dup_after", 32'(bus.dup_cnt), 32'd3);
    // asynchronous reset mid-cycle
    @(negedge clk);
    drive(4'h1, {33'h0, 11'h200}, 1'b0, 1'b0);
    #2 chk("arst.pre_ready", 32'(bus.eng_ready), 32'h1);
    rst = 1'b0;
    #1;
    chk("arst.ready", 32'(bus.eng_ready), 32'h0);
    chk("arst.dup_cnt", 32'(bus.dup_cnt), 32'd0);
    chk("arst.uca2ucq", 32'(bus.uca2ucq), 32'd0);
    chk("arst.push", 32'(bus.push), 32'd0);
    @(negedge clk);
    drive(4'h0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    drive(4'h4, {11'h0, 11'h222, 22'h0}, 1'b0, 1'b0);
    #2 chk("arst.regrant", 32'(bus.eng_ready), 32'h4);
    @(negedge clk);
    drive(4'h0, '0, 1'b0, 1'b0);
    #2;
    chk("arst.regrant_push", 32'(bus.push), 32'd1);
    chk("arst.regrant_lit", 32'(bus.uca2ucq), 32'h222);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
